// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - opcode/memory handshake and datapath control bundle
interface multicycle_controller_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       Opcode;
    logic             mem_ready;
    logic             pc_write;
    logic             branch;
    logic             ir_write;
    logic             adr_src;
    logic             mem_read;
    logic             mem_write;
    logic             reg_write;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       result_src;
    logic [1:0]       ALUOp;
    logic             illegal_op;
    logic             bus_error;
    logic [3:0]       state_dbg;
    logic [CNT_W-1:0] retired;

    modport master (
        input  Opcode, mem_ready,
        output pc_write, branch, ir_write, adr_src, mem_read, mem_write, reg_write,
               alu_src_a, alu_src_b, result_src, ALUOp,
               illegal_op, bus_error, state_dbg, retired
    );

    modport slave (
        output Opcode, mem_ready,
        input  pc_write, branch, ir_write, adr_src, mem_read, mem_write, reg_write,
               alu_src_a, alu_src_b, result_src, ALUOp,
               illegal_op, bus_error, state_dbg, retired
    );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multi-cycle RISC-V main control FSM with wait states, timeout and traps
module multicycle_controller #(
    parameter bit ENABLE_BRANCH = 1'b1,
    parameter bit ENABLE_JAL    = 1'b1,
    parameter int MEM_TIMEOUT   = 16,
    parameter int CNT_W         = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_EXEC_I = 4'd7,
        S_ALUWB  = 4'd8,
        S_BEQ    = 4'd9,
        S_JAL    = 4'd10,
        S_TRAP   = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam int         TW      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t           state, state_n;
    logic [TW-1:0]    tcnt;
    logic [CNT_W-1:0] ret_cnt;
    logic             illegal_q, bus_err_q;
    logic             retire, set_illegal, set_bus_err;
    logic             waiting, timed_out;

    // Only the three memory-handshake states can stall on mem_ready.
    assign waiting   = ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR)) && !bus.mem_ready;
    assign timed_out = waiting && (MEM_TIMEOUT != 0) && (tcnt == TW'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            tcnt      <= '0;
            ret_cnt   <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state <= state_n;
            tcnt  <= (waiting && state_n == state) ? tcnt + 1'b1 : '0;
            if (retire)      ret_cnt   <= ret_cnt + 1'b1;
            if (set_illegal) illegal_q <= 1'b1;
            if (set_bus_err) bus_err_q <= 1'b1;
        end
    end

    always_comb begin
        state_n        = state;
        retire         = 1'b0;
        set_illegal    = 1'b0;
        set_bus_err    = 1'b0;
        bus.pc_write   = 1'b0;
        bus.branch     = 1'b0;
        bus.ir_write   = 1'b0;
        bus.adr_src    = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.reg_write  = 1'b0;
        bus.alu_src_a  = 2'b00;
        bus.alu_src_b  = 2'b00;
        bus.result_src = 2'b00;
        bus.ALUOp      = 2'b00;
        case (state)
            S_FETCH: begin
                bus.mem_read   = 1'b1;
                bus.alu_src_b  = 2'b10;
                bus.ALUOp      = 2'b01;
                bus.result_src = 2'b10;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    state_n      = S_DECODE;
                end else if (timed_out) begin
                    state_n     = S_TRAP;
                    set_bus_err = 1'b1;
                end
            end
            S_DECODE: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b01;
                bus.ALUOp     = 2'b01;
                if (bus.Opcode == OP_LW || bus.Opcode == OP_SW)  state_n = S_MEMADR;
                else if (bus.Opcode == OP_R)                     state_n = S_EXEC_R;
                else if (bus.Opcode == OP_I)                     state_n = S_EXEC_I;
                else if (bus.Opcode == OP_BEQ && ENABLE_BRANCH)  state_n = S_BEQ;
                else if (bus.Opcode == OP_JAL && ENABLE_JAL)     state_n = S_JAL;
                else begin
                    state_n     = S_TRAP;
                    set_illegal = 1'b1;
                end
            end
            S_MEMADR: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                bus.ALUOp     = 2'b01;
                state_n       = (bus.Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                bus.adr_src  = 1'b1;
                bus.mem_read = 1'b1;
                if (bus.mem_ready) state_n = S_MEMWB;
                else if (timed_out) begin
                    state_n     = S_TRAP;
                    set_bus_err = 1'b1;
                end
            end
            S_MEMWB: begin
                bus.result_src = 2'b01;
                bus.reg_write  = 1'b1;
                retire         = 1'b1;
                state_n        = S_FETCH;
            end
            S_MEMWR: begin
                bus.adr_src   = 1'b1;
                bus.mem_write = 1'b1;
                if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_n = S_FETCH;
                end else if (timed_out) begin
                    state_n     = S_TRAP;
                    set_bus_err = 1'b1;
                end
            end
            S_EXEC_R: begin
                bus.alu_src_a = 2'b10;
                bus.ALUOp     = 2'b10;
                state_n       = S_ALUWB;
            end
            S_EXEC_I: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                state_n       = S_ALUWB;
            end
            S_ALUWB: begin
                bus.reg_write = 1'b1;
                retire        = 1'b1;
                state_n       = S_FETCH;
            end
            S_BEQ: begin
                bus.alu_src_a = 2'b10;
                bus.ALUOp     = 2'b11;
                bus.branch    = 1'b1;
                retire        = 1'b1;
                state_n       = S_FETCH;
            end
            S_JAL: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                bus.ALUOp     = 2'b01;
                bus.pc_write  = 1'b1;
                state_n       = S_ALUWB;
            end
            default: state_n = S_TRAP;
        endcase
        // Reset wins over any strobe the current state would raise.
        if (reset) begin
            bus.pc_write  = 1'b0;
            bus.branch    = 1'b0;
            bus.ir_write  = 1'b0;
            bus.mem_read  = 1'b0;
            bus.mem_write = 1'b0;
            bus.reg_write = 1'b0;
        end
    end

    assign bus.illegal_op = illegal_q;
    assign bus.bus_error  = bus_err_q;
    assign bus.state_dbg  = state;
    assign bus.retired    = ret_cnt;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - scoreboard bench for multicycle_controller across three parameter sets
module tb_multicycle_controller;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3,
                           MEMWB = 4'd4, MEMWR = 4'd5, EXEC_R = 4'd6, EXEC_I = 4'd7,
                           ALUWB = 4'd8, BEQ = 4'd9, JAL = 4'd10, TRAP = 4'd11;

    typedef struct {
        int          d;
        logic [3:0]  st;
        logic [14:0] ctl;
        logic        ill;
        logic        be;
        logic [31:0] ret;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    multicycle_controller_if #(.CNT_W(32)) ia ();
    multicycle_controller_if #(.CNT_W(4))  ib ();
    multicycle_controller_if #(.CNT_W(32)) ic ();

    multicycle_controller dut_a (.clk(clk), .reset(rst_a), .bus(ia));
    multicycle_controller #(.ENABLE_BRANCH(1'b1), .ENABLE_JAL(1'b0), .MEM_TIMEOUT(4), .CNT_W(4))
        dut_b (.clk(clk), .reset(rst_b), .bus(ib));
    multicycle_controller #(.ENABLE_BRANCH(1'b1), .ENABLE_JAL(1'b1), .MEM_TIMEOUT(0), .CNT_W(32))
        dut_c (.clk(clk), .reset(rst_c), .bus(ic));

    logic [14:0] ctl_a, ctl_b, ctl_c;
    assign ctl_a = {ia.pc_write, ia.branch, ia.ir_write, ia.mem_read, ia.mem_write, ia.reg_write,
                    ia.adr_src, ia.alu_src_a, ia.alu_src_b, ia.result_src, ia.ALUOp};
    assign ctl_b = {ib.pc_write, ib.branch, ib.ir_write, ib.mem_read, ib.mem_write, ib.reg_write,
                    ib.adr_src, ib.alu_src_a, ib.alu_src_b, ib.result_src, ib.ALUOp};
    assign ctl_c = {ic.pc_write, ic.branch, ic.ir_write, ic.mem_read, ic.mem_write, ic.reg_write,
                    ic.adr_src, ic.alu_src_a, ic.alu_src_b, ic.result_src, ic.ALUOp};

    // Hand-entered control table: {pc_write,branch,ir_write,mem_read,mem_write,reg_write} and {adr,a,b,res,aluop}.
    function automatic logic [14:0] ctl_of(input logic [3:0] st, input logic rdy, input logic rst);
        logic [5:0] s;
        logic [8:0] m;
        s = 6'b0;
        m = 9'b0;
        case (st)
            FETCH:  begin s = {rdy, 1'b0, rdy, 1'b1, 2'b00}; m = {1'b0, 2'b00, 2'b10, 2'b10, 2'b01}; end
            DECODE: m = {1'b0, 2'b01, 2'b01, 2'b00, 2'b01};
            MEMADR: m = {1'b0, 2'b10, 2'b01, 2'b00, 2'b01};
            MEMRD:  begin s = 6'b000100; m = {1'b1, 8'b0}; end
            MEMWB:  begin s = 6'b000001; m = {1'b0, 2'b00, 2'b00, 2'b01, 2'b00}; end
            MEMWR:  begin s = 6'b000010; m = {1'b1, 8'b0}; end
            EXEC_R: m = {1'b0, 2'b10, 2'b00, 2'b00, 2'b10};
            EXEC_I: m = {1'b0, 2'b10, 2'b01, 2'b00, 2'b00};
            ALUWB:  s = 6'b000001;
            BEQ:    begin s = 6'b010000; m = {1'b0, 2'b10, 2'b00, 2'b00, 2'b11}; end
            JAL:    begin s = 6'b100000; m = {1'b0, 2'b01, 2'b10, 2'b00, 2'b01}; end
            default: ;
        endcase
        if (rst) s = 6'b0;
        return {s, m};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic cyc(input int d, input logic rst, input logic [6:0] op, input logic rdy,
                       input logic [3:0] st, input logic ill, input logic be, input int unsigned ret);
        exp_t e;
        case (d)
            0:       begin rst_a = rst; ia.Opcode = op; ia.mem_ready = rdy; end
            1:       begin rst_b = rst; ib.Opcode = op; ib.mem_ready = rdy; end
            default: begin rst_c = rst; ic.Opcode = op; ic.mem_ready = rdy; end
        endcase
        e.d   = d;
        e.st  = st;
        e.ctl = ctl_of(st, rdy, rst);
        e.ill = ill;
        e.be  = be;
        e.ret = ret;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t        e;
            logic [3:0]  st;
            logic [14:0] ctl;
            logic        ill, be;
            logic [31:0] ret;
            e = sb.pop_front();
            case (e.d)
                0:       begin st = ia.state_dbg; ctl = ctl_a; ill = ia.illegal_op; be = ia.bus_error; ret = ia.retired; end
                1:       begin st = ib.state_dbg; ctl = ctl_b; ill = ib.illegal_op; be = ib.bus_error; ret = {28'b0, ib.retired}; end
                default: begin st = ic.state_dbg; ctl = ctl_c; ill = ic.illegal_op; be = ic.bus_error; ret = ic.retired; end
            endcase
            chk($sformatf("dut%0d.state", e.d), {28'b0, st}, {28'b0, e.st});
            chk($sformatf("dut%0d.ctl(st%0d)", e.d, e.st), {17'b0, ctl}, {17'b0, e.ctl});
            chk($sformatf("dut%0d.flags", e.d), {30'b0, ill, be}, {30'b0, e.ill, e.be});
            chk($sformatf("dut%0d.retired", e.d), ret, e.ret);
        end
    end

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        ia.Opcode = 7'b0; ia.mem_ready = 1'b0;
        ib.Opcode = 7'b0; ib.mem_ready = 1'b0;
        ic.Opcode = 7'b0; ic.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // add, then lw with 3 wait cycles in MEMRD
        cyc(0, 0, OP_R, 1, FETCH, 0, 0, 0);  cyc(0, 0, OP_R, 1, DECODE, 0, 0, 0);
        cyc(0, 0, OP_R, 1, EXEC_R, 0, 0, 0); cyc(0, 0, OP_R, 1, ALUWB, 0, 0, 0);
        cyc(0, 0, OP_LW, 1, FETCH, 0, 0, 1); cyc(0, 0, OP_LW, 1, DECODE, 0, 0, 1);
        cyc(0, 0, OP_LW, 1, MEMADR, 0, 0, 1);
        repeat (3) cyc(0, 0, OP_LW, 0, MEMRD, 0, 0, 1);
        cyc(0, 0, OP_LW, 1, MEMRD, 0, 0, 1); cyc(0, 0, OP_LW, 1, MEMWB, 0, 0, 1);
        // sw, beq, jal
        cyc(0, 0, OP_SW, 1, FETCH, 0, 0, 2);  cyc(0, 0, OP_SW, 1, DECODE, 0, 0, 2);
        cyc(0, 0, OP_SW, 1, MEMADR, 0, 0, 2); cyc(0, 0, OP_SW, 1, MEMWR, 0, 0, 2);
        cyc(0, 0, OP_BEQ, 1, FETCH, 0, 0, 3); cyc(0, 0, OP_BEQ, 1, DECODE, 0, 0, 3);
        cyc(0, 0, OP_BEQ, 1, BEQ, 0, 0, 3);
        cyc(0, 0, OP_JAL, 1, FETCH, 0, 0, 4); cyc(0, 0, OP_JAL, 1, DECODE, 0, 0, 4);
        cyc(0, 0, OP_JAL, 1, JAL, 0, 0, 4);   cyc(0, 0, OP_JAL, 1, ALUWB, 0, 0, 4);
        // addi with two fetch wait states
        cyc(0, 0, OP_I, 0, FETCH, 0, 0, 5);  cyc(0, 0, OP_I, 0, FETCH, 0, 0, 5);
        cyc(0, 0, OP_I, 1, FETCH, 0, 0, 5);  cyc(0, 0, OP_I, 1, DECODE, 0, 0, 5);
        cyc(0, 0, OP_I, 1, EXEC_I, 0, 0, 5); cyc(0, 0, OP_I, 1, ALUWB, 0, 0, 5);
        // illegal opcode traps until reset
        cyc(0, 0, OP_BAD, 1, FETCH, 0, 0, 6); cyc(0, 0, OP_BAD, 1, DECODE, 0, 0, 6);
        cyc(0, 0, OP_BAD, 1, TRAP, 1, 0, 6);  cyc(0, 0, OP_BAD, 1, TRAP, 1, 0, 6);
        cyc(0, 1, OP_BAD, 1, TRAP, 1, 0, 6);
        // reset during MEMWR aborts the store
        cyc(0, 0, OP_SW, 1, FETCH, 0, 0, 0);  cyc(0, 0, OP_SW, 1, DECODE, 0, 0, 0);
        cyc(0, 0, OP_SW, 1, MEMADR, 0, 0, 0); cyc(0, 1, OP_SW, 1, MEMWR, 0, 0, 0);
        cyc(0, 0, OP_SW, 0, FETCH, 0, 0, 0);

        // CNT_W = 4: 17 addi wrap the counter to 1
        for (int i = 0; i < 17; i++) begin
            cyc(1, 0, OP_I, 1, FETCH, 0, 0, i % 16);  cyc(1, 0, OP_I, 1, DECODE, 0, 0, i % 16);
            cyc(1, 0, OP_I, 1, EXEC_I, 0, 0, i % 16); cyc(1, 0, OP_I, 1, ALUWB, 0, 0, i % 16);
        end
        // JAL disabled decodes as illegal
        cyc(1, 0, OP_JAL, 1, FETCH, 0, 0, 1); cyc(1, 0, OP_JAL, 1, DECODE, 0, 0, 1);
        cyc(1, 0, OP_JAL, 1, TRAP, 1, 0, 1);  cyc(1, 1, OP_JAL, 0, TRAP, 1, 0, 1);
        // MEM_TIMEOUT = 4 in FETCH
        repeat (4) cyc(1, 0, OP_R, 0, FETCH, 0, 0, 0);
        cyc(1, 0, OP_R, 0, TRAP, 0, 1, 0);
        cyc(1, 0, OP_R, 1, TRAP, 0, 1, 0);

        // MEM_TIMEOUT = 0 waits indefinitely
        repeat (40) cyc(2, 0, OP_R, 0, FETCH, 0, 0, 0);
        cyc(2, 0, OP_R, 1, FETCH, 0, 0, 0);  cyc(2, 0, OP_R, 1, DECODE, 0, 0, 0);
        cyc(2, 0, OP_R, 1, EXEC_R, 0, 0, 0); cyc(2, 0, OP_R, 1, ALUWB, 0, 0, 0);
        cyc(2, 0, OP_R, 0, FETCH, 0, 0, 1);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
